// File: rtl/fbcpu_boot_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fbcpu_boot_loader                                              |
// | Function : Holds FBCPU in reset, streams a program image into block RAM   |
// |            from address 0, zero-fills the remainder, then releases the   |
// |            CPU and hands the RAM port to the CPU's MAR/MDRIn/RAMWr.      |
// | Options  : FBCPU_BOOT_CHECKSUM_EN - the i_last word is a checksum of the |
// |            data words (mod 2**DATA_WIDTH) and is not written to RAM.     |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fbcpu_boot_loader #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int MEM_DEPTH     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic                     i_last,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  input  logic                     cpu_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  output logic                     ram_we,
  output logic                     o_cpu_rst,
  output logic                     o_done,
  output logic                     o_err,
  output logic [ADDRESS_WIDTH:0]   o_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] c_LAST_ADDR = ADDRESS_WIDTH'(MEM_DEPTH - 1);

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_ptr;
  logic [ADDRESS_WIDTH:0]   r_count;
  logic                     r_cpuRst;
  logic                     r_done;
  logic                     r_err;
`ifdef FBCPU_BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]    r_sum;
`endif

  logic w_handshake;
  logic w_atEnd;

  assign o_ready     = (r_state == S_LOAD);
  assign w_handshake = i_valid & o_ready;
  assign w_atEnd     = (r_ptr == c_LAST_ADDR);

  assign o_cpu_rst = r_cpuRst;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_count   = r_count;

  // RAM port steering: loader owns it during LOAD/CLEAR, CPU only in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (r_state)
      S_LOAD: begin
`ifdef FBCPU_BOOT_CHECKSUM_EN
        ram_we    = w_handshake & ~i_last;
`else
        ram_we    = w_handshake;
`endif
        ram_addr  = r_ptr;
        ram_wdata = i_data;
      end
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = r_ptr;
        ram_wdata = '0;
      end
      S_RUN: begin
        // A reload request cuts the CPU off in the same cycle.
        ram_we    = cpu_we & ~i_start;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      default: begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_count  <= '0;
      r_cpuRst <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef FBCPU_BOOT_CHECKSUM_EN
      r_sum    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (i_start) begin
            r_state  <= S_LOAD;
            r_ptr    <= '0;
            r_count  <= '0;
            r_cpuRst <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
`ifdef FBCPU_BOOT_CHECKSUM_EN
            r_sum    <= '0;
`endif
          end
        end

        S_LOAD: begin
          if (w_handshake) begin
`ifdef FBCPU_BOOT_CHECKSUM_EN
            if (i_last) begin
              // Checksum slot was never written, so clearing starts at r_ptr.
              if (i_data == r_sum) begin
                r_state <= S_CLEAR;
              end else begin
                r_state <= S_ERROR;
                r_err   <= 1'b1;
              end
            end else begin
              r_ptr   <= r_ptr + ADDRESS_WIDTH'(1);
              r_count <= r_count + (ADDRESS_WIDTH+1)'(1);
              r_sum   <= r_sum + i_data;
              if (w_atEnd) begin
                r_state <= S_ERROR;
                r_err   <= 1'b1;
              end
            end
`else
            r_ptr   <= r_ptr + ADDRESS_WIDTH'(1);
            r_count <= r_count + (ADDRESS_WIDTH+1)'(1);
            if (w_atEnd) begin
              if (i_last) begin
                r_state  <= S_RUN;
                r_cpuRst <= 1'b0;
                r_done   <= 1'b1;
              end else begin
                r_state <= S_ERROR;
                r_err   <= 1'b1;
              end
            end else if (i_last) begin
              r_state <= S_CLEAR;
            end
`endif
          end
        end

        S_CLEAR: begin
          r_ptr <= r_ptr + ADDRESS_WIDTH'(1);
          if (w_atEnd) begin
            r_state  <= S_RUN;
            r_cpuRst <= 1'b0;
            r_done   <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fbcpu_boot_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fbcpu_boot_loader                                           |
// | Function : Directed self-checking bench for fbcpu_boot_loader with a     |
// |            behavioural block-RAM model on the loader's RAM port.         |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fbcpu_boot_loader;

  localparam int AW    = 6;
  localparam int DW    = 10;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data = '0;
  logic          i_last = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          o_cpu_rst;
  logic          o_done;
  logic          o_err;
  logic [AW:0]   o_count;

  int total = 0;
  int bad   = 0;
  int weViolations = 0;
  logic scrub = 1'b0;

  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] expMem [DEPTH];

  fbcpu_boot_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_last(i_last), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .o_cpu_rst(o_cpu_rst), .o_done(o_done), .o_err(o_err), .o_count(o_count)
  );

  always #5 clk = ~clk;

  // Block RAM model; scrub fills it with a stale pattern so zero-fill is visible.
  always @(posedge clk) begin
    if (scrub) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 10'h155;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  always @(negedge clk) begin
    if (ram_we && o_ready && !i_valid) weViolations++;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doScrub();
    scrub = 1'b1;
    tick();
    scrub = 1'b0;
  endtask

  task automatic pulseStart();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic sendWord(input logic [DW-1:0] d, input logic last, input int gap);
    int n;
    repeat (gap) tick();
    n = 0;
    while (!o_ready && n < 200) begin
      tick();
      n++;
    end
    if (!o_ready) check("readyWait", o_ready, 1);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    tick();
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = '0;
  endtask

  task automatic waitRun(input int budget, output int cycles);
    cycles = -1;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if (o_done) begin
        cycles = n;
        return;
      end
    end
  endtask

  task automatic compareRam(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== expMem[i]) mism++;
    check(tag, mism, 0);
  endtask

  task automatic setImage(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input logic [DW-1:0] w2, input int n);
    for (int i = 0; i < DEPTH; i++) expMem[i] = '0;
    if (n > 0) expMem[0] = w0;
    if (n > 1) expMem[1] = w1;
    if (n > 2) expMem[2] = w2;
  endtask

  initial begin
    int cyc;
    logic [DW-1:0] w;
    logic [DW-1:0] s;

    // Reset: CPU write attempts must not reach RAM
    rst = 1'b0;
    cpu_we = 1'b1; cpu_addr = 6'd7; cpu_wdata = 10'h3C3;
    doScrub();
    repeat (9) tick();
    check("rstCpuRst", o_cpu_rst, 1);
    check("rstDone",   o_done,    0);
    check("rstErr",    o_err,     0);
    check("rstReady",  o_ready,   0);
    check("rstCount",  o_count,   0);
    check("rstRamWe",  ram_we,    0);
    cpu_we = 1'b0;
    rst = 1'b1;
    tick();

    // 1: back-to-back three word image
    pulseStart();
    check("loadReady", o_ready, 1);
`ifdef FBCPU_BOOT_CHECKSUM_EN
    sendWord(10'h001, 1'b0, 0);
    sendWord(10'h002, 1'b0, 0);
    sendWord(10'h3FF, 1'b0, 0);
    sendWord(10'h002, 1'b1, 0);   // 1+2+0x3FF mod 1024
`else
    sendWord(10'h001, 1'b0, 0);
    sendWord(10'h002, 1'b0, 0);
    sendWord(10'h3FF, 1'b1, 0);
`endif
    waitRun(200, cyc);
    check("clearCycles1", cyc, 61);
    check("runCpuRst1", o_cpu_rst, 0);
    check("count1", o_count, 3);
    setImage(10'h001, 10'h002, 10'h3FF, 3);
    check("ram2", mem[2], 10'h3FF);
    check("ram63", mem[63], 0);
    compareRam("image1");

    // 2: same image with gaps, restarted from RUN
    doScrub();
    pulseStart();
    check("restartCpuRst", o_cpu_rst, 1);
    check("restartDone", o_done, 0);
    sendWord(10'h001, 1'b0, $urandom_range(1, 5));
    sendWord(10'h002, 1'b0, $urandom_range(1, 5));
`ifdef FBCPU_BOOT_CHECKSUM_EN
    sendWord(10'h3FF, 1'b0, $urandom_range(1, 5));
    sendWord(10'h002, 1'b1, $urandom_range(1, 5));
`else
    sendWord(10'h3FF, 1'b1, $urandom_range(1, 5));
`endif
    waitRun(200, cyc);
    check("clearCycles2", cyc, 61);
    check("count2", o_count, 3);
    compareRam("image2");
    check("weNoHandshake", weViolations, 0);

    // 4: CPU owns RAM in RUN; reload request blocks same-cycle CPU write
    cpu_addr = 6'd52; cpu_wdata = 10'd50; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    check("cpuWrite52", mem[52], 50);
    cpu_addr = 6'd10; cpu_wdata = 10'h2AA; cpu_we = 1'b1; i_start = 1'b1;
    #3;
    check("weOnStart", ram_we, 0);
    tick();
    i_start = 1'b0; cpu_we = 1'b0;
    check("startCpuRst", o_cpu_rst, 1);
    check("startDone", o_done, 0);
    check("cpuBlocked10", mem[10], 0);

`ifndef FBCPU_BOOT_CHECKSUM_EN
    // 3a: full 64-word image, no clear phase
    for (int i = 0; i < DEPTH; i++) begin
      w = DW'((i * 7 + 3) & 10'h3FF);
      expMem[i] = w;
      sendWord(w, (i == DEPTH - 1), 0);
    end
    check("fullDone", o_done, 1);
    check("fullCpuRst", o_cpu_rst, 0);
    check("fullCount", o_count, 64);
    compareRam("imageFull");
    pulseStart();
`endif

    // 3b: 64 words without i_last overflows
    for (int i = 0; i < DEPTH; i++) sendWord(DW'(i + 100), 1'b0, 0);
    check("ovfErr", o_err, 1);
    check("ovfCpuRst", o_cpu_rst, 1);
    check("ovfReady", o_ready, 0);
    check("ovfLastWord", mem[63], 163);
    tick();
    check("ovfHold", o_err, 1);

    // 5: reset in the middle of a load, then a fresh load
    pulseStart();
    check("errCleared", o_err, 0);
    for (int i = 0; i < 10; i++) sendWord(DW'(i + 20), 1'b0, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midRstReady", o_ready, 0);
    check("midRstCount", o_count, 0);
    check("midRstCpuRst", o_cpu_rst, 1);
    pulseStart();
`ifdef FBCPU_BOOT_CHECKSUM_EN
    sendWord(10'd11, 1'b0, 0);
    sendWord(10'd22, 1'b0, 0);
    sendWord(10'd33, 1'b0, 0);
    sendWord(10'd66, 1'b1, 0);
    waitRun(200, cyc);
    check("clearCycles5", cyc, 61);
    check("count5", o_count, 3);
    setImage(10'd11, 10'd22, 10'd33, 3);
`else
    sendWord(10'd11, 1'b0, 0);
    sendWord(10'd22, 1'b0, 0);
    sendWord(10'd33, 1'b0, 0);
    sendWord(10'd44, 1'b1, 0);
    waitRun(200, cyc);
    check("clearCycles5", cyc, 60);
    check("count5", o_count, 4);
    setImage(10'd11, 10'd22, 10'd33, 3);
    expMem[3] = 10'd44;
`endif
    compareRam("image5");

`ifdef FBCPU_BOOT_CHECKSUM_EN
    // 6: checksum match and mismatch
    pulseStart();
    sendWord(10'd5, 1'b0, 0);
    sendWord(10'd7, 1'b0, 0);
    s = 10'd12;
    sendWord(s, 1'b1, 0);
    waitRun(200, cyc);
    check("ckClear", cyc, 62);
    check("ckCount", o_count, 2);
    check("ckRam2", mem[2], 0);
    pulseStart();
    sendWord(10'd5, 1'b0, 0);
    sendWord(10'd7, 1'b0, 0);
    sendWord(10'd13, 1'b1, 0);
    check("ckBadErr", o_err, 1);
    check("ckBadCpuRst", o_cpu_rst, 1);
    pulseStart();
    sendWord(10'd0, 1'b1, 0);
    waitRun(200, cyc);
    check("ckEmpty", cyc, 64);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fbcpu_boot_loader.md
Name: fbcpu_boot_loader

Overview:
Program loader sitting between the host word stream, FBCPU and the block RAM. It holds FBCPU in reset, streams a program image into RAM from address 0 and zero-fills the rest. It then releases the CPU and hands the RAM port over to the CPU's MAR/MDRIn/RAMWr signals. This lets a bench or host reload programs without re-elaborating the memory image.

Parameters:
ADDRESS_WIDTH, 6, RAM address width (matches FBCPU MAR)
DATA_WIDTH, 10, RAM word width (matches FBCPU MDR)
MEM_DEPTH, 64, number of RAM words; must equal 2**ADDRESS_WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
i_start  input  1  pulse: begin a load (accepted in IDLE, RUN, ERROR)
i_valid  input  1  stream word valid
o_ready  output  1  loader accepts a stream word
i_data  input  DATA_WIDTH  stream word
i_last  input  1  marks final stream word
cpu_addr  input  ADDRESS_WIDTH  from FBCPU MAR
cpu_wdata  input  DATA_WIDTH  from FBCPU MDRIn
cpu_we  input  1  from FBCPU RAMWr
ram_addr  output  ADDRESS_WIDTH  to blram i_addr
ram_wdata  output  DATA_WIDTH  to blram i_ram_data_in
ram_we  output  1  to blram i_we
o_cpu_rst  output  1  active-high reset to FBCPU
o_done  output  1  image loaded, CPU running
o_err  output  1  load failed
o_count  output  ADDRESS_WIDTH+1  data words accepted in the current or last load

Behaviour:
- Reset (rst==0 at posedge): state IDLE, ptr=0, o_count=0, o_cpu_rst=1, o_done=0, o_err=0. Outputs while in reset/IDLE: o_ready=0, ram_we=0, ram_addr=0, ram_wdata=0. RAM contents are untouched by reset, including a partially written image.
- States: IDLE, LOAD, CLEAR, RUN, ERROR. All state, ptr and status flags are registered.
- IDLE: i_start -> LOAD, ptr=0, o_count=0.
- LOAD: o_ready=1 (decoded from state). Handshake is i_valid & o_ready.
  - On handshake, ram_we=1, ram_addr=ptr and ram_wdata=i_data, all combinational in the same cycle. ptr and o_count then increment.
  - Handshake with i_last, ptr<MEM_DEPTH-1 -> CLEAR.
  - Handshake with i_last, ptr==MEM_DEPTH-1 -> RUN. No clear cycles.
  - Handshake without i_last at ptr==MEM_DEPTH-1 -> word written, then ERROR (overflow).
  - No handshake: ram_we=0 and state holds. Gaps of any length are allowed.
- CLEAR: o_ready=0. Each cycle ram_we=1, ram_addr=ptr, ram_wdata=0, ptr++. After writing MEM_DEPTH-1 -> RUN. Total clear cycles = MEM_DEPTH - words loaded.
- RUN: o_cpu_rst=0 and o_done=1, both registered, so they are valid from the first RUN cycle. The RAM port mirrors cpu_addr/cpu_wdata/cpu_we combinationally. i_start -> LOAD: o_cpu_rst=1 and o_done=0 next cycle, and cpu_we is ignored from the i_start cycle onward.
- ERROR: o_err=1, o_cpu_rst=1, o_ready=0, ram_we=0. i_start -> LOAD and clears o_err.
- i_start in LOAD or CLEAR: ignored.
- cpu_* inputs are ignored in every state except RUN.

Optional Feature:
FBCPU_BOOT_CHECKSUM_EN
- Defined: the i_last word is a checksum and is not written to RAM; o_count excludes it.
  - The loader keeps a running sum of the data words, mod 2**DATA_WIDTH.
  - Match -> CLEAR starting at the current ptr. ptr==MEM_DEPTH-1 is included, because that slot was not written.
  - Mismatch -> ERROR.
  - An i_last arriving with zero data words: the sum is 0 and is compared against it.
  - Overflow rule unchanged: a non-last word at ptr==MEM_DEPTH-1 -> ERROR.
- Undefined: no checksum logic; the i_last word is data, as described in Behaviour.

Test Plan:
1. rst low 10 cycles, i_start, stream 0x001,0x002,0x3FF(last) with no gaps.
   -> RAM[0..2]=1,2,0x3FF; RAM[3..63]=0.
   -> o_done=1 and o_cpu_rst=0 exactly 61 cycles after the last handshake; o_count=3.
2. Same image with i_valid deasserted for 1–5 random cycles between words.
   -> identical RAM contents; ram_we never high without a handshake.
3. 64 words with i_last on word 63 -> RUN with zero clear cycles, o_count=64.
   Separately, 64 words with no i_last -> o_err=1, o_cpu_rst stays 1, o_ready=0.
4. In RUN drive cpu_addr=52, cpu_wdata=50, cpu_we=1 for 1 cycle -> RAM[52]=50.
   Then i_start -> o_cpu_rst=1 next cycle, and a cpu_we in that cycle does not write.
5. rst low after 10 words of a load -> next cycle IDLE, o_ready=0, o_count=0, o_cpu_rst=1.
   A fresh i_start and 4-word load completes normally.
6. (FBCPU_BOOT_CHECKSUM_EN) stream 5,7,checksum 12 -> RUN, o_count=2, RAM[2]=0.
   Stream 5,7,checksum 13 -> ERROR, o_err=1.
